div_unit: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned divider paired with the EX stage for DIV/DIVU.
//  EX issues operands with a start handshake and stalls the pipeline while busy.
//  EX consumes {remainder, quotient} and forwards it as hi_o/lo_o with whilo_o=1.

---
 rtl/div_unit.sv | 139 +++++++++++++
 tb/tb_div_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held in END until the requester drops start_i.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [2*DATA_W:0]     work, work_nxt, step;
  logic [DATA_W-1:0]     dvsr, dvsr_nxt;
  logic                  neg_q, neg_q_nxt;
  logic                  neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0]   result_nxt;
  logic                  ready_nxt;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic neg);
    return neg ? -v : v;
  endfunction

  // Work register is {partial remainder (DATA_W+1), dividend/quotient (DATA_W)};
  // the trial subtraction uses one guard bit so its sign is the borrow.
  function automatic logic [2*DATA_W:0] restore_step(input logic [2*DATA_W:0] w,
                                                     input logic [DATA_W-1:0] d);
    logic [2*DATA_W:0] sh;
    logic [DATA_W+1:0] diff;
    sh   = {w[2*DATA_W-1:0], 1'b0};
    diff = {1'b0, sh[2*DATA_W:DATA_W]} - {2'b00, d};
    if (!diff[DATA_W+1])
      return {diff[DATA_W:0], sh[DATA_W-1:1], 1'b1};
    else
      return sh;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvsr_nxt   = dvsr;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result_o;
    ready_nxt  = ready_o;
    step       = restore_step(work, dvsr);
    case (state)
      FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt = ON;
            cnt_nxt   = '0;
            work_nxt  = {{(DATA_W+1){1'b0}}, magnitude(opdata1_i, signed_div_i)};
            dvsr_nxt  = magnitude(opdata2_i, signed_div_i);
            neg_q_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          state_nxt  = END;
          result_nxt = '0;
          ready_nxt  = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          work_nxt = step;
          cnt_nxt  = cnt + CNT_W'(1);
          // Last step lands straight in END with the sign fix-up applied.
          if (cnt == LAST_STEP) begin
            state_nxt  = END;
            ready_nxt  = 1'b1;
            result_nxt = {neg_if(step[2*DATA_W-1:DATA_W], neg_r),
                          neg_if(step[DATA_W-1:0], neg_q)};
          end
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_nxt  = FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      dvsr     <= dvsr_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// DIV/DIVU operations compared against a plain-arithmetic reference.
module tb_div_unit;

  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: language division truncates toward zero, remainder takes dividend sign.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
    int lat;
    int want;
    want = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom_range(0, 1));
    while (!ready_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(want));
    check({tag, " result"}, result_o, exp);
    @(posedge clk); #1;
    check({tag, " hold ready"}, 64'(ready_o), 64'd1);
    check({tag, " hold result"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, 64'(ready_o), 64'd0);
    check({tag, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          bad;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle ready", 64'(ready_o), 64'd0);

    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu 100/7");
    run_div(1'b1, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div -7/2");
    run_div(1'b1, 32'd7, -32'sd2, 64'h00000001_FFFFFFFD, "div 7/-2");
    run_div(1'b0, 32'd5, 32'd0, 64'd0, "divu 5/0");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "div min/-1");
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, "divu min/ffff");

    // Annul in the middle of iteration: no result ever appears.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk) annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) bad = 1;
    end
    check("annul no ready", 64'(bad), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "divu 9/3 after annul");

    // Reset between edges while iterating, then a fresh divide from FREE.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst on ready", 64'(ready_o), 64'd0);
    check("rst on result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "divu 100/7 after rst");

    // Reset between edges while holding a result must clear it without a clock.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    bad = 1;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) bad = 0;
    end
    check("end reached", 64'(bad), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rst end ready", 64'(ready_o), 64'd0);
    check("rst end result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'($urandom_range(0, 200));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'd1;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, model(sgn, a, b), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
